// File: rtl/gray_counter.sv
// Gray-code up/down counter with level enable, step-edge counting,
// synchronous binary preload, and registered step/wrap pulses.
module gray_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         step,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    output logic [W-1:0] g,
    output logic         stepped,
    output logic         wrap
);

    localparam int unsigned CW = W;

    logic [CW-1:0] r_b;
    logic [CW-1:0] r_g;
    logic          r_step_d;
    logic          r_stepped;
    logic          r_wrap;

    logic          w_step_rise;
    logic          w_cnt_req;
    logic          w_at_max;
    logic          w_at_min;
    logic [CW-1:0] w_b_inc;
    logic [CW-1:0] w_b_dec;
    logic [CW-1:0] w_b_next;
    logic [CW-1:0] w_g_next;
    logic          w_stepped_next;
    logic          w_wrap_next;

    // Count request: level enable or a fresh rising edge on step; both together give one count.
    always_comb begin
        w_step_rise = step & ~r_step_d;
        w_cnt_req   = en | w_step_rise;
        w_at_max    = (r_b == {CW{1'b1}});
        w_at_min    = (r_b == {CW{1'b0}});
        w_b_inc     = CW'(r_b + CW'(1));
        w_b_dec     = CW'(r_b - CW'(1));
    end

    // Next binary count, its Gray image and the pulse flags; load beats any count request.
    always_comb begin
        w_b_next       = r_b;
        w_stepped_next = 1'b0;
        w_wrap_next    = 1'b0;
        if (load) begin
            w_b_next       = load_bin;
            w_stepped_next = 1'b1;
        end else if (w_cnt_req) begin
            w_b_next       = up ? w_b_inc : w_b_dec;
            w_stepped_next = 1'b1;
            w_wrap_next    = (up & w_at_max) | (~up & w_at_min);
        end
        w_g_next = w_b_next ^ (w_b_next >> 1);
    end

    // State and output registers; Gray word is updated on the same edge as the binary count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b       <= '0;
            r_g       <= '0;
            r_step_d  <= 1'b0;
            r_stepped <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_b       <= w_b_next;
            r_g       <= w_g_next;
            r_step_d  <= step;
            r_stepped <= w_stepped_next;
            r_wrap    <= w_wrap_next;
        end
    end

    assign g       = r_g;
    assign stepped = r_stepped;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Directed, table-driven bench for gray_counter at W=4.
module tb_gray_counter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         step;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] g;
    logic         stepped;
    logic         wrap;

    int n_tests;
    int n_fail;

    typedef struct {
        string        name;
        logic         en;
        logic         step;
        logic         up;
        logic         load;
        logic [W-1:0] bin;
        logic [W-1:0] g;
        logic         st;
        logic         wr;
        logic         ham;
    } vec_t;

    vec_t vq[$];

    gray_counter #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .step     (step),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .g        (g),
        .stepped  (stepped),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic e, input logic s, input logic u,
                       input logic l, input logic [W-1:0] b, input logic [W-1:0] eg,
                       input logic est, input logic ewr, input logic ham);
        vec_t v;
        v.name = name; v.en = e; v.step = s; v.up = u; v.load = l; v.bin = b;
        v.g = eg; v.st = est; v.wr = ewr; v.ham = ham;
        vq.push_back(v);
    endtask

    initial begin
        logic [W-1:0] prev_g;
        logic [W-1:0] up_seq [16];
        n_tests = 0;
        n_fail  = 0;

        up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        // Up sweep from 0: sixteen counts, wrap only on return to 0000.
        for (int i = 0; i < 16; i++)
            add($sformatf("up_sweep_%0d", i), 1, 0, 1, 0, 4'h0, up_seq[i], 1, (i == 15), 1);
        // Down wrap from 0.
        add("down_wrap",      1, 0, 0, 0, 4'h0, 4'b1000, 1, 1, 1);
        add("down_after",     1, 0, 0, 0, 4'h0, 4'b1001, 1, 0, 1);
        // Load beats a coincident enable.
        add("load_0101",      1, 0, 1, 1, 4'b0101, 4'b0111, 1, 0, 0);
        add("after_load_up",  1, 0, 1, 0, 4'h0, 4'b0101, 1, 0, 1);
        add("idle_hold",      0, 0, 1, 0, 4'h0, 4'b0101, 0, 0, 0);
        // Load of all-ones then an up count wraps.
        add("load_1111",      0, 0, 1, 1, 4'b1111, 4'b1000, 1, 0, 0);
        add("load_wrap_up",   0, 1, 1, 0, 4'h0, 4'b0000, 1, 1, 1);
        // Step edges: high 5, low 3, high 2 gives two counts.
        add("step_pre_low",   0, 0, 1, 0, 4'h0, 4'b0000, 0, 0, 0);
        add("step_h1",        0, 1, 1, 0, 4'h0, 4'b0001, 1, 0, 1);
        add("step_h2",        0, 1, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_h3",        0, 1, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_h4",        0, 1, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_h5",        0, 1, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_l1",        0, 0, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_l2",        0, 0, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_l3",        0, 0, 1, 0, 4'h0, 4'b0001, 0, 0, 0);
        add("step_h6",        0, 1, 1, 0, 4'h0, 4'b0011, 1, 0, 1);
        add("step_h7",        0, 1, 1, 0, 4'h0, 4'b0011, 0, 0, 0);
        // Coincident enable and step edge: one increment only.
        add("coin_low",       0, 0, 1, 0, 4'h0, 4'b0011, 0, 0, 0);
        add("coin_both",      1, 1, 1, 0, 4'h0, 4'b0010, 1, 0, 1);
        add("coin_en",        1, 1, 1, 0, 4'h0, 4'b0110, 1, 0, 1);
        // Reverse direction at 0110.
        add("flip_down1",     1, 1, 0, 0, 4'h0, 4'b0010, 1, 0, 1);
        add("flip_down2",     1, 0, 0, 0, 4'h0, 4'b0011, 1, 0, 1);

        rst = 1'b1; en = 1'b0; step = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_g", 32'(g), 32'h0);
        check("rst_stepped", 32'(stepped), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;

        // Asynchronous reset mid-count, then resume from 0.
        en = 1'b1; up = 1'b1;
        repeat (3) tick();
        check("pre_rst_g", 32'(g), 32'b0010);
        #3 rst = 1'b1;
        #1;
        check("async_rst_g", 32'(g), 32'h0);
        check("async_rst_stepped", 32'(stepped), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        #2 rst = 1'b0;
        tick();
        check("resume_g", 32'(g), 32'b0001);
        check("resume_stepped", 32'(stepped), 32'h1);

        // Clean reset before the table.
        en = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        prev_g = g;

        foreach (vq[i]) begin
            en = vq[i].en; step = vq[i].step; up = vq[i].up;
            load = vq[i].load; load_bin = vq[i].bin;
            tick();
            check({vq[i].name, "_g"}, 32'(g), 32'(vq[i].g));
            check({vq[i].name, "_stepped"}, 32'(stepped), 32'(vq[i].st));
            check({vq[i].name, "_wrap"}, 32'(wrap), 32'(vq[i].wr));
            if (vq[i].ham)
                check({vq[i].name, "_hamming"}, 32'($countones(g ^ prev_g)), 32'd1);
            prev_g = g;
        end

        // Step already high at reset release gives exactly one count.
        en = 1'b0; load = 1'b0; up = 1'b1; step = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        check("step_at_release_g", 32'(g), 32'b0001);
        check("step_at_release_stepped", 32'(stepped), 32'h1);
        tick();
        check("step_held_g", 32'(g), 32'b0001);
        check("step_held_stepped", 32'(stepped), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterised Gray-code up/down counter that produces the Gray word consumed by the downstream Gray-to-binary converter.
- Counts on a level enable or on single-step rising edges from a slow push-button-style input.
- Supports synchronous binary preload.
- Flags every step and every wrap-around with one-cycle pulses.
- Every count transition changes exactly one bit of `g`, so the consumer sees a clean Gray sequence.

## Interface
- `W`, default 4, counter width in bits; legal range 2..8.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: continuous count enable; one count per clock while high.
- `step` input 1: single-step request; one count per 0→1 transition, already synchronous to `clk`.
- `up` input 1: direction; 1 = increment, 0 = decrement; sampled at each count.
- `load` input 1: synchronous preload strobe.
- `load_bin` input W: binary preload value.
- `g` output W: registered Gray-code count.
- `stepped` output 1: registered one-cycle pulse, high in the cycle after any count or load took effect.
- `wrap` output 1: registered one-cycle pulse on a count that wraps (up from 2^W−1 to 0, or down from 0 to 2^W−1).

## Operation
- Internal state:
  - `b`: W-bit binary count.
  - `step_d`: 1-bit previous `step`.
  - `g`, `stepped`, `wrap` registers.
- `g` is always `b ^ (b >> 1)`, registered in the same edge that updates `b`; no combinational path from inputs to `g`.
- `step_rise = step & ~step_d`; `step_d <= step` every cycle.
- `cnt_req = en | step_rise`. When `en` and `step_rise` coincide, exactly one count occurs.
- Priority per clock edge:
  1. `load`: `b <= load_bin`, `g <= load_bin ^ (load_bin>>1)`, `stepped <= 1`, `wrap <= 0`. Any count request in the same cycle is discarded.
  2. else `cnt_req`:
     - `b <= up ? b+1 : b−1`, modulo 2^W.
     - `stepped <= 1`.
     - `wrap <= (up & b==2^W−1) | (~up & b==0)`.
  3. else: `b`, `g` hold; `stepped <= 0`; `wrap <= 0`.
- Direction may change between any two counts; the sequence reverses with no skipped or repeated code.
- Arithmetic is modulo 2^W; no saturation and no overflow state.

## Timing
- Reset (asynchronous, immediate): `b = 0`, `g = 0`, `step_d = 0`, `stepped = 0`, `wrap = 0`.
- If `step` is already high at reset release, one `step_rise` is seen on the first edge after release, giving one count. This is required behaviour.
- Latency: a request sampled on edge N appears on `g`, `stepped` and `wrap` after edge N. `stepped` and `wrap` then hold for exactly one cycle unless another request follows.
- With `en` held high, `g` advances every cycle and `stepped` stays high continuously.
- Reset asserted mid-count forces the reset values asynchronously. Counting resumes from 0 on the first edge after deassertion.
- Between consecutive counts the Hamming distance of `g` is exactly 1. A load may change any number of bits.

## Test plan
- **Reset:** assert `rst` mid-cycle with `en=1` → `g=0000`, `stepped=0`, `wrap=0` immediately, without waiting for a clock edge. After release with `en=1, up=1`, `g` reads 0001 after the first edge.
- **Up sweep (W=4):** `en=1, up=1` for 16 cycles → `g` = 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. `wrap=1` only on the cycle `g` returns to 0000. The checker confirms single-bit change on every cycle.
- **Down wrap:** from reset, `en=1, up=0` for 1 cycle → `g=1000`, `wrap=1`. The next cycle gives `g=1001`, `wrap=0`.
- **Load:** `load=1, load_bin=0101` with `en=1` in the same cycle → `g=0111`, `stepped=1`, no count. The next cycle with `up=1` gives `g=0101`.
- **Step edges:** `en=0`; hold `step` high for 5 cycles, low for 3, high for 2 → exactly two counts, `g` 0000→0001→0011. `stepped` pulses once per rising edge.
- **Coincident requests:** `en=1` and a `step` rising edge in the same cycle → a single increment. Flip `up` mid-sweep at `g=0110` → the next `g` is 0010.
